// File: rtl/voice_allocator_if.sv
// Event handshake from the MIDI framer plus the per-voice outputs toward the
// voice array. The master side produces events, the slave side allocates.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4
) ();
  logic                      midi_event_valid;
  logic [7:0]                midi_command;
  logic [6:0]                midi_parameter_1;
  logic [6:0]                midi_parameter_2;
  logic                      midi_event_ack;
  logic [NUM_VOICES-1:0]     voice_gate;
  logic [7*NUM_VOICES-1:0]   voice_note;
  logic [NUM_VOICES-1:0]     voice_load;
  logic                      busy;

  modport master (
    output midi_event_valid, midi_command, midi_parameter_1, midi_parameter_2,
    input  midi_event_ack, voice_gate, voice_note, voice_load, busy
  );

  modport slave (
    input  midi_event_valid, midi_command, midi_parameter_1, midi_parameter_2,
    output midi_event_ack, voice_gate, voice_note, voice_load, busy
  );
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: least-recently-allocated ranking with voice
// stealing, one voice examined per cycle during the scan.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int OMNI       = 1,
  parameter int CHANNEL    = 0
) (
  input logic              clk,
  input logic              rst,
  voice_allocator_if.slave bus
);
  localparam int RW = $clog2(NUM_VOICES);

  typedef enum logic [2:0] {IDLE, SCAN, COMMIT, ACK, HOLD} state_t;
  typedef enum logic [1:0] {EV_ON, EV_OFF, EV_ANO} event_t;

  state_t                state_q, state_d;
  event_t                kind_q;
  logic [6:0]            p1_q;
  logic [RW-1:0]         idx_q;
  logic                  match_found_q, free_found_q;
  logic [RW-1:0]         match_idx_q, free_idx_q, free_rank_q, old_idx_q;
  logic [NUM_VOICES-1:0] mask_q;
  logic [NUM_VOICES-1:0] gate_q, load_q;
  logic [6:0]            note_q [NUM_VOICES];
  logic [RW-1:0]         rank_q [NUM_VOICES];
  logic                  chan_ok, is_on, is_off, is_ano;
  logic [RW-1:0]         target;

  // Classify the event currently presented on the bus.
  always_comb begin
    chan_ok = (OMNI != 0) || (bus.midi_command[3:0] == 4'(CHANNEL));
    is_on   = chan_ok && (bus.midi_command[7:4] == 4'h9) && (bus.midi_parameter_2 != 7'd0);
    is_off  = chan_ok && ((bus.midi_command[7:4] == 4'h8) ||
              ((bus.midi_command[7:4] == 4'h9) && (bus.midi_parameter_2 == 7'd0)));
    is_ano  = chan_ok && (bus.midi_command[7:4] == 4'hB) && (bus.midi_parameter_1 == 7'h7B);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    state_d            = state_q;
    bus.midi_event_ack = 1'b0;
    bus.busy           = (state_q != IDLE);
    case (state_q)
      IDLE: if (bus.midi_event_valid) begin
        if (is_on || is_off) state_d = SCAN;
        else if (is_ano)     state_d = COMMIT;
        else                 state_d = ACK;
      end
      SCAN:    if (idx_q == RW'(NUM_VOICES - 1)) state_d = COMMIT;
      COMMIT:  state_d = ACK;
      ACK: begin
        bus.midi_event_ack = 1'b1;
        state_d            = HOLD;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Voice chosen for a note-on: retrigger, else oldest free, else steal oldest.
  always_comb begin
    target = old_idx_q;
    if (match_found_q)     target = match_idx_q;
    else if (free_found_q) target = free_idx_q;
  end

  // Event latch, scan trackers and per-voice gate/note/rank state.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q        <= EV_ANO;
      p1_q          <= '0;
      idx_q         <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
      free_rank_q   <= '0;
      old_idx_q     <= '0;
      mask_q        <= '0;
      gate_q        <= '0;
      load_q        <= '0;
      // NOTE: the note and rank arrays are reset explicitly: notes are
      // visible outputs and the ranks must start as a valid permutation.
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        rank_q[i] <= RW'(NUM_VOICES - 1 - i);
      end
    end else begin
      load_q <= '0;
      case (state_q)
        IDLE: if (bus.midi_event_valid) begin
          kind_q        <= is_on ? EV_ON : (is_off ? EV_OFF : EV_ANO);
          p1_q          <= bus.midi_parameter_1;
          idx_q         <= '0;
          match_found_q <= 1'b0;
          free_found_q  <= 1'b0;
          mask_q        <= '0;
        end
        SCAN: begin
          idx_q <= idx_q + RW'(1);
          if (gate_q[idx_q] && (note_q[idx_q] == p1_q)) begin
            mask_q[idx_q] <= 1'b1;
            if (!match_found_q) begin
              match_found_q <= 1'b1;
              match_idx_q   <= idx_q;
            end
          end
          if (!gate_q[idx_q] && (!free_found_q || (rank_q[idx_q] > free_rank_q))) begin
            free_found_q <= 1'b1;
            free_idx_q   <= idx_q;
            free_rank_q  <= rank_q[idx_q];
          end
          if (rank_q[idx_q] == RW'(NUM_VOICES - 1)) old_idx_q <= idx_q;
        end
        COMMIT: begin
          case (kind_q)
            EV_ON: begin
              note_q[target] <= p1_q;
              gate_q[target] <= 1'b1;
              load_q[target] <= 1'b1;
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (RW'(i) == target)               rank_q[i] <= '0;
                else if (rank_q[i] < rank_q[target]) rank_q[i] <= rank_q[i] + RW'(1);
              end
            end
            EV_OFF:  gate_q <= gate_q & ~mask_q;
            default: gate_q <= '0;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Flatten the per-voice state onto the bus.
  always_comb begin
    bus.voice_gate = gate_q;
    bus.voice_load = load_q;
    bus.voice_note = '0;
    for (int i = 0; i < NUM_VOICES; i++) bus.voice_note[7*i +: 7] = note_q[i];
  end
endmodule
